instr_fetch_responder: RTL
==========================

# instr_fetch_responder

Instruction-memory responder on the fetch side of the PC register: accepts fetch requests carrying a PC value and returns the instruction word at that address over a valid/ready response channel. It holds a loadable program memory mapped at the text base 0x0040_0000. A registered read stage feeds a 3-entry response FIFO, so the block sustains one fetch per cycle while tolerating response back-pressure. Out-of-range and misaligned fetches complete with a fault flag instead of stalling.

## Interface
- DATA_WIDTH, 32, instruction word width
- ADDR_WIDTH, 32, fetch address width
- DEPTH, 64, program memory size in words; power of two
- BASE_ADDR, 32'h0040_0000, byte address of memory word 0
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- req_valid  input  1  fetch request present
- req_addr  input  ADDR_WIDTH  byte address (PC value) to fetch
- req_ready  output  1  block accepts the request this cycle
- rsp_valid  output  1  response at FIFO head valid
- rsp_data  output  DATA_WIDTH  instruction word
- rsp_addr  output  ADDR_WIDTH  address the response belongs to
- rsp_fault  output  1  request was misaligned or out of range
- rsp_ready  input  1  consumer takes the response this cycle
- load_en  input  1  write load_data into program memory
- load_index  input  log2(DEPTH)  word index to write
- load_data  input  DATA_WIDTH  word to write
- fault_count  output  8  saturating count of faulted fetches

## Operation
- Accept: a request is taken on an edge where req_valid && req_ready are both 1.
- Address check at accept:
  - off = req_addr - BASE_ADDR.
  - Fault if req_addr[1:0] != 0, or req_addr < BASE_ADDR, or off[ADDR_WIDTH-1:2] >= DEPTH.
  - Otherwise the word index is off[2 +: log2(DEPTH)].
- Stage S1 (registered read):
  - On accept, S1 captures the memory word, req_addr and the fault flag; s1_valid is set to 1.
  - On a faulted request, rsp_data is 32'h0000_0013 (NOP) and memory is not indexed.
- FIFO: on every edge with s1_valid=1, S1 is pushed into the 3-entry FIFO, in order.
- Pop: on an edge with rsp_valid && rsp_ready. Push and pop may happen on the same edge.
- Outputs: rsp_* come from the FIFO head. rsp_valid = (count != 0). When empty, rsp_data, rsp_addr and rsp_fault are 0.
- Flow control: req_ready = !reset && (count + s1_valid <= 2). It depends only on registers and reset, never on rsp_ready or req_valid. This guarantees the FIFO never overflows.
- Load port:
  - On an edge with load_en=1, mem[load_index] <= load_data, independent of fetch traffic.
  - If the same edge reads the same index, the fetch returns the old word (read-before-write).
- Fault counter: fault_count increments by 1 on each accepted faulted request and saturates at 255.
- Reset (reset=1 at an edge):
  - Clears s1_valid, the FIFO (count=0, pointers=0) and fault_count.
  - In-flight and queued responses are discarded.
  - Memory contents are preserved.
  - A load_en asserted during reset is still performed.

## Timing
- Reset values: rsp_valid=0, rsp_data=0, rsp_addr=0, rsp_fault=0, fault_count=0. req_ready=0 while reset=1; req_ready=1 in the first cycle after reset deasserts.
- Latency: a request accepted at edge k produces rsp_valid=1 after edge k+1, provided the FIFO is not full of older entries.
- Throughput: with rsp_ready held at 1, one request is accepted every cycle indefinitely. Steady state is count=1, s1_valid=1.
- Back-pressure: with rsp_ready=0, exactly 3 requests are accepted, then req_ready=0. req_ready returns to 1 the cycle after the first pop.
- Ordering: responses leave in strict acceptance order, including faulted ones.
- rsp_* outputs are stable while rsp_valid=1 and rsp_ready=0.

## Test plan
- Load mem[0..3] = 0x11,0x22,0x33,0x44. Fetch 0x0040_0000..0x0040_000C back-to-back with rsp_ready=1 → responses 0x11,0x22,0x33,0x44 on consecutive cycles, first one 2 edges after the first accept, rsp_fault=0, req_ready stays 1.
- Hold rsp_ready=0 and drive req_valid=1 continuously → exactly 3 accepts, then req_ready=0. Raise rsp_ready → the 3 responses drain in order and req_ready reasserts after the first pop.
- Fetch 0x0040_0002, 0x003F_FFFC and 0x0040_0100 (DEPTH=64) → three responses with rsp_fault=1, rsp_data=0x13 and matching rsp_addr; fault_count=3.
- On the same edge, load_en=1 writing index 5 = 0xAAAA and a fetch of 0x0040_0014 accepted with old value 0x5555 → the response is 0x5555; a later fetch of the same address returns 0xAAAA.
- With 2 entries queued and 1 in S1, assert reset for 1 cycle → rsp_valid=0 and fault_count=0 after the edge, no stale response ever appears, and a post-reset fetch of 0x0040_0000 returns mem[0].
- Issue 260 faulted fetches → fault_count saturates at 255.

Source files
------------

// File: rtl/instr_fetch_responder.sv
// Instruction fetch responder: program memory at BASE_ADDR, one registered read
// stage feeding a 3-entry response FIFO, with fault reporting for bad PCs.
module instr_fetch_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int DEPTH      = 64,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = ADDR_WIDTH'(32'h0040_0000)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    input  logic [ADDR_WIDTH-1:0]    req_addr,
    output logic                     req_ready,
    output logic                     rsp_valid,
    output logic [DATA_WIDTH-1:0]    rsp_data,
    output logic [ADDR_WIDTH-1:0]    rsp_addr,
    output logic                     rsp_fault,
    input  logic                     rsp_ready,
    input  logic                     load_en,
    input  logic [$clog2(DEPTH)-1:0] load_index,
    input  logic [DATA_WIDTH-1:0]    load_data,
    output logic [7:0]               fault_count
);
    localparam int IW = $clog2(DEPTH);
    localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] addr;
        logic                  fault;
    } rsp_t;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    rsp_t                  s1;
    logic                  s1_valid;
    rsp_t                  fifo [3];
    logic [1:0]            wr_ptr, rd_ptr, count;

    logic [ADDR_WIDTH-3:0] woff;
    logic                  req_fault, accept, push, pop;
    logic [2:0]            occupancy;
    rsp_t                  head;

    // Base is word aligned, so the word offset never borrows from the byte bits.
    assign woff      = req_addr[ADDR_WIDTH-1:2] - BASE_ADDR[ADDR_WIDTH-1:2];
    assign req_fault = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                       (woff >= (ADDR_WIDTH-2)'(DEPTH));

    assign occupancy = {1'b0, count} + {2'b00, s1_valid};
    assign req_ready = !reset && (occupancy <= 3'd2);
    assign accept    = req_valid && req_ready;
    assign push      = s1_valid;
    assign pop       = (count != 2'd0) && rsp_ready;

    assign head      = fifo[rd_ptr];
    assign rsp_valid = (count != 2'd0);
    assign rsp_data  = rsp_valid ? head.data  : '0;
    assign rsp_addr  = rsp_valid ? head.addr  : '0;
    assign rsp_fault = rsp_valid ? head.fault : 1'b0;

    // Loads ignore reset so a program can be preloaded while the core is held.
    always_ff @(posedge clk) begin
        if (load_en)
            mem[load_index] <= load_data;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            s1.addr  <= req_addr;
            s1.fault <= req_fault;
            s1.data  <= req_fault ? NOP : mem[woff[IW-1:0]];
        end
        if (push)
            fifo[wr_ptr] <= s1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid    <= 1'b0;
            wr_ptr      <= 2'd0;
            rd_ptr      <= 2'd0;
            count       <= 2'd0;
            fault_count <= 8'd0;
        end else begin
            s1_valid <= accept;
            if (push)
                wr_ptr <= (wr_ptr == 2'd2) ? 2'd0 : wr_ptr + 2'd1;
            if (pop)
                rd_ptr <= (rd_ptr == 2'd2) ? 2'd0 : rd_ptr + 2'd1;
            case ({push, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (accept && req_fault && fault_count != 8'hFF)
                fault_count <= fault_count + 8'd1;
        end
    end
endmodule
